// File: rtl/sram_port_arbiter.sv
// ============================================================================
// Module  : sram_port_arbiter
// Brief   : Two-client arbiter and strobe sequencer for the shared 2K x 16 SRAM.
//           Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (client 0 wins ties).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_port_arbiter #(
   parameter int AW = 11,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [AW-1:0] sram_adrx,
   output logic          sram_noe,
   output logic          sram_read,
   output logic          sram_dq_oe,
   output logic [DW-1:0] sram_dout,
   input  logic [DW-1:0] sram_din
);

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WR_STROBE  = 3'd1,
      S_WR_RELEASE = 3'd2,
      S_RD_ADDR    = 3'd3,
      S_RD_CAPTURE = 3'd4,
      S_DONE       = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          win_q, win_d;
   logic          pick;
   logic          any_req;

   assign any_req = req0 | req1;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   assign pick = ~req0;
`else
   logic last_q, last_d;

   // On a tie the client not granted last time wins; otherwise the lone requester.
   assign pick = (req0 & req1) ? ~last_q : req1;

   always_comb begin
      last_d = last_q;
      if (state_q == S_IDLE && any_req) begin
         last_d = pick;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      win_d   = win_q;
      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               win_d   = pick;
               addr_d  = pick ? addr1  : addr0;
               wdata_d = pick ? wdata1 : wdata0;
               state_d = (pick ? we1 : we0) ? S_WR_STROBE : S_RD_ADDR;
            end
         end
         S_WR_STROBE:  state_d = S_WR_RELEASE;
         S_WR_RELEASE: state_d = S_DONE;
         S_RD_ADDR:    state_d = S_RD_CAPTURE;
         S_RD_CAPTURE: begin
            rdata_d = sram_din;
            state_d = S_DONE;
         end
         S_DONE:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         win_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         win_q   <= win_d;
      end
   end

   // Strobes decode from state alone so a reset releases them on the very next edge;
   // address and data stay on their registers between grants for long hold margins.
   always_comb begin
      sram_noe   = 1'b1;
      sram_read  = 1'b1;
      sram_dq_oe = 1'b0;
      ack0       = 1'b0;
      ack1       = 1'b0;
      case (state_q)
         S_WR_STROBE: begin
            sram_read  = 1'b0;
            sram_dq_oe = 1'b1;
         end
         S_WR_RELEASE: sram_dq_oe = 1'b1;
         S_RD_ADDR:    sram_noe   = 1'b0;
         S_RD_CAPTURE: sram_noe   = 1'b0;
         S_DONE: begin
            ack0 = ~win_q;
            ack1 = win_q;
         end
         default: ;
      endcase
   end

   assign busy      = (state_q != S_IDLE) | (any_req & ~rst);
   assign sram_adrx = addr_q;
   assign sram_dout = wdata_q;
   assign rdata     = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
// ============================================================================
// Module  : tb_sram_port_arbiter
// Brief   : Directed and randomized checks of sram_port_arbiter against a
//           transaction-level model with a behavioural SRAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_port_arbiter;

   localparam int AW = 11;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1, busy;
   logic [DW-1:0] rdata;
   logic [AW-1:0] sram_adrx;
   logic          sram_noe, sram_read, sram_dq_oe;
   logic [DW-1:0] sram_dout, sram_din;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] mem     [0:2047] = '{default: 16'h0};
   logic [DW-1:0] ref_mem [0:2047] = '{default: 16'h0};
   logic [DW-1:0] ref_rdata;
   bit            ref_last;

   always #5 clk = ~clk;

   sram_port_arbiter #(.AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
      .sram_adrx(sram_adrx), .sram_noe(sram_noe), .sram_read(sram_read),
      .sram_dq_oe(sram_dq_oe), .sram_dout(sram_dout), .sram_din(sram_din)
   );

   // Behavioural SRAM: writes while the strobe is low, reads while output-enabled.
   always @(posedge clk) begin
      if (!sram_read) mem[sram_adrx] <= sram_dout;
   end
   assign sram_din = sram_dq_oe ? sram_dout : (!sram_noe ? mem[sram_adrx] : 16'h0000);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("bus_contention", {31'd0, sram_dq_oe & ~sram_noe}, 32'd0);
   endtask

   function automatic bit model_winner(input bit r0, input bit r1);
`ifdef SRAM_ARB_FIXED_PRIO_EN
      return r0 ? 1'b0 : 1'b1;
`else
      if (r0 && r1) return ~ref_last;
      return r1;
`endif
   endfunction

   // Presents requests at the current negedge (DUT assumed idle) and follows the
   // granted transaction to its ack; returns positioned at the next idle cycle.
   task automatic txn(input bit r0, input bit r1, input bit w0, input bit w1,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      bit            win, w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      win = model_winner(r0, r1);
      ref_last = win;
      w = win ? w1 : w0;
      a = win ? a1 : a0;
      d = win ? d1 : d0;
      req0 = r0; req1 = r1; we0 = w0; we1 = w1;
      addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
      #1 chk("busy_at_grant", {31'd0, busy}, 32'd1);
      tick();
      // Inputs scrambled after the grant must not disturb the latched transaction.
      req0 = 0; req1 = 0; addr0 = 11'h7FF; addr1 = 11'h7FF; wdata0 = ~d; wdata1 = ~d;
      chk("p1_adrx", {21'd0, sram_adrx}, {21'd0, a});
      chk("p1_read", {31'd0, sram_read}, {31'd0, ~w});
      chk("p1_noe", {31'd0, sram_noe}, {31'd0, w});
      chk("p1_dq_oe", {31'd0, sram_dq_oe}, {31'd0, w});
      if (w) chk("p1_dout", {16'd0, sram_dout}, {16'd0, d});
      tick();
      chk("p2_adrx", {21'd0, sram_adrx}, {21'd0, a});
      chk("p2_read", {31'd0, sram_read}, 32'd1);
      chk("p2_noe", {31'd0, sram_noe}, {31'd0, w});
      chk("p2_dq_oe", {31'd0, sram_dq_oe}, {31'd0, w});
      if (w) chk("p2_dout", {16'd0, sram_dout}, {16'd0, d});
      tick();
      if (w) ref_mem[a] = d;
      else ref_rdata = ref_mem[a];
      chk("done_ack0", {31'd0, ack0}, {31'd0, ~win});
      chk("done_ack1", {31'd0, ack1}, {31'd0, win});
      chk("done_busy", {31'd0, busy}, 32'd1);
      chk("done_adrx", {21'd0, sram_adrx}, {21'd0, a});
      chk("done_noe_oe", {30'd0, sram_noe, sram_dq_oe}, 32'd2);
      chk("done_rdata", {16'd0, rdata}, {16'd0, ref_rdata});
      tick();
      chk("idle_busy_ack", {29'd0, busy, ack0, ack1}, 32'd0);
      chk("idle_rdata", {16'd0, rdata}, {16'd0, ref_rdata});
   endtask

   initial begin
      bit            r0, r1;
      logic [AW-1:0] ra0, ra1;
      rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      ref_rdata = '0; ref_last = 1'b1;
      repeat (3) tick();
      chk("rst_adrx", {21'd0, sram_adrx}, 32'd0);
      chk("rst_strobes", {29'd0, sram_noe, sram_read, sram_dq_oe}, 32'd6);
      chk("rst_dout", {16'd0, sram_dout}, 32'd0);
      chk("rst_ack_busy", {29'd0, ack0, ack1, busy}, 32'd0);
      chk("rst_rdata", {16'd0, rdata}, 32'd0);

      // Tie held from reset: acks every 4 cycles, client 0 first.
      req0 = 1; req1 = 1; addr0 = 11'h003; addr1 = 11'h004;
      tick();
      rst = 0;
      for (int k = 0; k < 16; k++) begin
         bit exp_win;
         tick();
`ifdef SRAM_ARB_FIXED_PRIO_EN
         exp_win = 1'b0;
`else
         exp_win = ((k / 4) % 2) == 1;
`endif
         chk("tie_ack0", {31'd0, ack0}, {31'd0, (k % 4 == 2) && !exp_win});
         chk("tie_ack1", {31'd0, ack1}, {31'd0, (k % 4 == 2) && exp_win});
      end
      req0 = 0; req1 = 0; rst = 1;
      repeat (2) tick();
      rst = 0;
      ref_last = 1'b1;
      tick();

      // Write then read on client 0; then address latching on client 1.
      txn(1, 0, 1, 0, 11'h005, 11'h000, 16'hBEEF, 16'h0000);
      txn(1, 0, 0, 0, 11'h005, 11'h000, 16'h0000, 16'h0000);
      chk("wr_rd_beef", {16'd0, ref_rdata}, 32'hBEEF);
      txn(0, 1, 0, 0, 11'h000, 11'h010, 16'h0000, 16'h0000);

      // Reset asserted while the write strobe is low.
      req0 = 1; we0 = 1; addr0 = 11'h020; wdata0 = 16'h1234;
      tick();
      chk("rs_strobe_low", {31'd0, sram_read}, 32'd0);
      req0 = 0; rst = 1;
      tick();
      rst = 0;
      ref_rdata = '0; ref_last = 1'b1;
      chk("rs_read", {31'd0, sram_read}, 32'd1);
      chk("rs_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      chk("rs_busy_ack", {29'd0, busy, ack0, ack1}, 32'd0);
      chk("rs_rdata", {16'd0, rdata}, 32'd0);
      tick();
      chk("rs_no_late_ack", {29'd0, busy, ack0, ack1}, 32'd0);

      // Random mixed traffic, ties included, on a small address pool.
      for (int i = 0; i < 128; i++) begin
         r0 = $urandom_range(0, 1);
         r1 = $urandom_range(0, 1);
         if (!r0 && !r1) r0 = 1;
         ra0 = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
         ra1 = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
         txn(r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra0, ra1,
             16'($urandom), 16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
